hoene_frame_sender: RTL and testbench
=====================================

Name: hoene_frame_sender

Overview:
- Host-side transmitter for the LED chain protocol; produces the serial Manchester stream that the first LED in the chain receives and decodes.
- Accepts 30-bit LED payload words over a valid/ready handshake and prepends the marker bit.
- Appends a parity bit, serialises each 32-bit word MSB-first and Manchester-encodes it onto one output line.
- Holds the line low for a fixed gap after each frame so receivers drop sync and restart at bit 0.

Parameters:
- HALF_PERIOD, 4, clk cycles per Manchester half-bit; legal range 1..255.
- GAP_BITS, 8, idle bit periods emitted after every frame end; legal range 1..255.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- s_valid  in  1  host word valid.
- s_ready  out  1  block can accept a word.
- s_marker  in  1  word bit 0, the first bit on the line ("LED takes this word").
- s_data  in  30  payload, transmitted as bits 1..30; s_data[29] goes first.
- s_last  in  1  word closes the frame.
- out_data  out  1  Manchester line to the chain DIN.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse when the gap after a frame completes.
- underrun  out  1  one-cycle pulse when the shifter empties mid-frame.

Behaviour:
- Reset (rst=1 at a clk edge) forces all outputs to 0 except s_ready=1, clears the holding register, returns to IDLE. Reset mid-word aborts immediately; the line is low next cycle.
- Word format: bit0 = s_marker, bits1..30 = s_data[29:0] MSB-first, bit31 = parity.
- Parity = XOR(bits 0..30) XOR PARITY_ODD.
- Manchester coding: 1 = low half then high half; 0 = high half then low half. Each half lasts HALF_PERIOD cycles.
- Idle and gap line level is constant 0.
- out_data is registered.
- Holding register: one word deep. s_ready = holding register empty.
- A transfer occurs when s_valid && s_ready. s_ready stays high even while a word is shifting, so the next word can be queued.
- FSM states:
  - IDLE: holding register full → load the shifter, go to SEND. The first half-bit appears on out_data the cycle after the load.
  - SEND: half-bit counter 0..HALF_PERIOD-1, phase flag, bit counter 0..31. At the end of bit 31:
    - word had s_last → GAP.
    - holding register full → load it on the same cycle, so the next word has no idle cycles between it and the previous one; stay in SEND.
    - otherwise → pulse underrun, go to GAP.
  - GAP: out_data=0 for GAP_BITS*2*HALF_PERIOD cycles, then pulse frame_done and go to IDLE. Words may be accepted into the holding register during GAP but are not sent before GAP ends.
- Latency: a word accepted at cycle T in IDLE loads at T+1; its first half-bit is on out_data at T+2.
- Simultaneous events:
  - A shifter load and a new acceptance in the same cycle are both legal; the accepted word fills the holding register just vacated.
  - rst has priority over every event.
- Counter widths: half-bit counter 8 bits, bit counter 5 bits, gap counter 16 bits.

Test Plan:
- Single word, HALF_PERIOD=2. Send marker=1, data=0x00000001, last=1. Parity=0. Required out_data from T+2: 0,0,1,1 (marker), then 29×(1,1,0,0), then 0,0,1,1 (data LSB), then 1,1,0,0 (parity). Then 32 cycles of 0, then frame_done pulses once.
- Back-to-back words: offer three words (last only on the third) with s_valid held high. Required: bit 31 of one word ends and bit 0 of the next starts with no idle cycles between; s_ready drops only while the holding register is full; no underrun; exactly one frame_done.
- Underrun: two-word frame where the second word arrives 10 cycles after the first word ends. Required: underrun pulses at the end of word 1, a full gap follows, and word 2 is sent as a new frame.
- Parity: data=0x3FFFFFFF, marker=0, PARITY_ODD=0 → bit31=0 (30 ones). Same word with PARITY_ODD=1 → bit31=1.
- Reset mid-word: assert rst at bit 12 of a word. Required on the next cycle: out_data=0, busy=0, s_ready=1. A word offered afterwards transmits cleanly from bit 0.
- Backpressure: hold s_valid with the holding register full. Required: s_ready=0, s_data held stable by the host, and the word is captured exactly once.

Source files
------------

// File: rtl/hoene_frame_sender.sv
// hoene_frame_sender
//   Host-side transmitter for the LED chain. It takes 30-bit payload words over
//   a valid/ready handshake and builds a 32-bit word from them:
//   {marker, data[29:0], parity}. The word goes out MSB-first (the marker is
//   bit 0 on the line) as a Manchester stream. A frame is closed by a fixed
//   low gap, which makes every receiver drop sync and restart at bit 0.
//
// Ports
//   clk, rst             clock and synchronous active-high reset
//   s_valid/s_ready      word handshake (one-deep holding register)
//   s_marker,s_data,s_last  word fields; s_last closes the frame
//   out_data             registered Manchester line (idle/gap = 0)
//   busy                 state != IDLE
//   frame_done           one-cycle pulse when the post-frame gap completes
//   underrun             one-cycle pulse when a frame runs dry before s_last
module hoene_frame_sender #(
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned GAP_BITS    = 8,
  parameter bit          PARITY_ODD  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_marker,
  input  logic [29:0] s_data,
  input  logic        s_last,
  output logic        out_data,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  typedef struct packed {
    logic [31:0] word;   // [31] is the first bit on the line
    logic        last;
  } word_t;

  localparam logic [7:0]  HP_M1  = 8'(HALF_PERIOD - 1);
  // The gap is counted in half-bit periods so a 16-bit counter covers the
  // full GAP_BITS x HALF_PERIOD range; half_cnt supplies the sub-count.
  localparam logic [15:0] GAP_M1 = 16'(2 * GAP_BITS - 1);

  state_t      state_q, state_d;
  word_t       hold_q, cur_q;
  logic        hold_full;
  logic [7:0]  half_cnt;
  logic        phase;      // 0 = first half of the bit, 1 = second half
  logic [4:0]  bit_cnt;
  logic [15:0] gap_cnt;

  logic accept, load, half_end, word_end;
  logic out_d, ur_d, fd_d;

  assign s_ready = !hold_full;
  assign busy    = (state_q != IDLE);
  assign accept  = s_valid && !hold_full;

  assign half_end = (half_cnt == HP_M1);
  assign word_end = half_end && phase && (bit_cnt == 5'd31);

  // Next state and next line level. out_data is registered, so out_d is the
  // level shown during the cycle after this edge.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    out_d   = out_data;
    ur_d    = 1'b0;
    fd_d    = 1'b0;
    case (state_q)
      IDLE: begin
        out_d = 1'b0;
        if (hold_full) begin
          load    = 1'b1;
          state_d = SEND;
          out_d   = ~hold_q.word[31];     // first half: 1 -> low, 0 -> high
        end
      end
      SEND: begin
        if (half_end) begin
          if (!phase) begin
            out_d = cur_q.word[31];       // second half carries the bit value
          end else if (bit_cnt != 5'd31) begin
            out_d = ~cur_q.word[30];      // first half of the following bit
          end else if (cur_q.last) begin
            state_d = GAP;
            out_d   = 1'b0;
          end else if (hold_full) begin
            // Chain straight into the queued word: no idle cycles.
            load  = 1'b1;
            out_d = ~hold_q.word[31];
          end else begin
            ur_d    = 1'b1;
            state_d = GAP;
            out_d   = 1'b0;
          end
        end
      end
      GAP: begin
        out_d = 1'b0;
        if (half_end && (gap_cnt == GAP_M1)) begin
          state_d = IDLE;
          fd_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        out_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      hold_full  <= 1'b0;
      cur_q      <= '0;
      half_cnt   <= '0;
      phase      <= 1'b0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      out_data   <= 1'b0;
      underrun   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_data   <= out_d;
      underrun   <= ur_d;
      frame_done <= fd_d;

      // An accept in the same cycle as a load refills the slot just vacated.
      if (accept) begin
        hold_q.word <= {s_marker, s_data, (^{s_marker, s_data}) ^ PARITY_ODD};
        hold_q.last <= s_last;
        hold_full   <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      if (load) begin
        cur_q    <= hold_q;
        half_cnt <= '0;
        phase    <= 1'b0;
        bit_cnt  <= '0;
      end else begin
        case (state_q)
          SEND: begin
            if (half_end) begin
              half_cnt <= '0;
              phase    <= ~phase;
              if (phase) begin
                bit_cnt    <= bit_cnt + 5'd1;
                cur_q.word <= {cur_q.word[30:0], 1'b0};
              end
              if (word_end) gap_cnt <= '0;
            end else begin
              half_cnt <= half_cnt + 8'd1;
            end
          end
          GAP: begin
            if (half_end) begin
              half_cnt <= '0;
              gap_cnt  <= gap_cnt + 16'd1;
            end else begin
              half_cnt <= half_cnt + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hoene_frame_sender.sv
// Testbench for hoene_frame_sender. Two instances share all inputs: dut0 uses
// even parity, dut1 odd parity; only their parity bits may differ. A monitor
// decodes the Manchester line and compares each word against a scoreboard
// filled at the moment the bench sees a word accepted.
module tb_hoene_frame_sender;

  localparam int HP    = 2;
  localparam int GB    = 8;
  localparam int GAPC  = GB * 2 * HP;

  logic        clk;
  logic        rst;
  logic        s_valid, s_marker, s_last;
  logic [29:0] s_data;
  logic        s_ready, out_data, busy, frame_done, underrun;
  logic        rdy1, out1, busy1, fd1, ur1;

  hoene_frame_sender #(.HALF_PERIOD(HP), .GAP_BITS(GB), .PARITY_ODD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_marker(s_marker), .s_data(s_data), .s_last(s_last),
    .out_data(out_data), .busy(busy), .frame_done(frame_done), .underrun(underrun)
  );

  hoene_frame_sender #(.HALF_PERIOD(HP), .GAP_BITS(GB), .PARITY_ODD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy1),
    .s_marker(s_marker), .s_data(s_data), .s_last(s_last),
    .out_data(out1), .busy(busy1), .frame_done(fd1), .underrun(ur1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w0;    // expected word, even parity
    logic [31:0] w1;    // expected word, odd parity
    logic        last;
  } exp_t;

  typedef struct {
    logic        m;
    logic [29:0] d;
    logic        pe;    // hand-computed even-parity bit
    logic        po;    // hand-computed odd-parity bit
  } vec_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   fd_cnt   = 0;
  int   ur_cnt   = 0;
  int   acc_cnt  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic par(input logic m, input logic [29:0] d);
    return ^{m, d};
  endfunction

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (underrun)   ur_cnt++;
  end

  // Offer one word (called at a negedge); hold it stable until accepted.
  task automatic send(input logic m, input logic [29:0] d, input logic l,
                      input logic pe, input logic po, output int stall);
    stall    = 0;
    s_marker = m;
    s_data   = d;
    s_last   = l;
    s_valid  = 1'b1;
    while (!s_ready && stall < 2000) begin
      @(negedge clk);
      stall++;
    end
    if (!s_ready) begin
      chk("accept_timeout", 32'(s_ready), 1);
    end else begin
      @(posedge clk);
      sb.push_back('{w0: {m, d, pe}, w1: {m, d, po}, last: l});
      acc_cnt++;
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_cnt(input bit use_ur, input int target, input string nm);
    int n = 0;
    while (((use_ur ? ur_cnt : fd_cnt) < target) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'((use_ur ? ur_cnt : fd_cnt) >= target), 1);
  endtask

  // Line monitor: decodes words while busy, then checks gap and frame_done.
  initial begin : monitor
    exp_t        e;
    logic [31:0] r0, r1;
    logic        f0, f1, aborted, more;
    int          bad, gbad;
    forever begin
      @(negedge clk);
      if (rst || !busy) continue;
      aborted = 1'b0;
      more    = 1'b1;
      while (more && !aborted) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", 32'(sb.size()), 1);
          aborted = 1'b1;
        end else begin
          e = sb.pop_front();
          r0 = '0; r1 = '0; bad = 0; f0 = 1'b0; f1 = 1'b0;
          for (int b = 0; b < 32 && !aborted; b++) begin
            for (int h = 0; h < 2 * HP && !aborted; h++) begin
              if (b != 0 || h != 0) @(negedge clk);
              if (rst) begin
                aborted = 1'b1;
              end else begin
                if (h == 0) begin
                  f0 = out_data;
                  f1 = out1;
                end
                if (h < HP) begin
                  if (out_data !== f0 || out1 !== f1) bad++;
                end else begin
                  if (out_data !== ~f0 || out1 !== ~f1) bad++;
                end
                if (h == 2 * HP - 1) begin
                  r0 = {r0[30:0], out_data};
                  r1 = {r1[30:0], out1};
                end
              end
            end
          end
          if (!aborted) begin
            chk("word_even", r0, e.w0);
            chk("word_odd", r1, e.w1);
            chk("manchester_halves", bad, 0);
            more = !e.last && (sb.size() > 0);
            if (more) @(negedge clk);
          end
        end
      end
      if (aborted) begin
        sb.delete();
        continue;
      end
      gbad = 0;
      for (int i = 0; i < GAPC && !aborted; i++) begin
        @(negedge clk);
        if (rst) aborted = 1'b1;
        if (out_data || out1 || !busy) gbad++;
        if (i == 0) chk("underrun_pulse", 32'(underrun), 32'(!e.last));
      end
      if (aborted) begin
        sb.delete();
        continue;
      end
      chk("gap_low", gbad, 0);
      @(negedge clk);
      chk("frame_done_pulse", {frame_done, busy}, 32'b10);
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $finish;
  end

  initial begin : driver
    vec_t tbl[6];
    int   st, fd0, ur0, a0, seen;

    tbl[0] = '{m: 1'b1, d: 30'h00000001, pe: 1'b0, po: 1'b1};
    tbl[1] = '{m: 1'b0, d: 30'h3FFFFFFF, pe: 1'b0, po: 1'b1};
    tbl[2] = '{m: 1'b1, d: 30'h3FFFFFFF, pe: 1'b1, po: 1'b0};
    tbl[3] = '{m: 1'b0, d: 30'h00000000, pe: 1'b0, po: 1'b1};
    tbl[4] = '{m: 1'b1, d: 30'h2AAAAAAA, pe: 1'b0, po: 1'b1};
    tbl[5] = '{m: 1'b0, d: 30'h12345678, pe: 1'b1, po: 1'b0};

    rst = 1'b1; s_valid = 1'b0; s_marker = 1'b0; s_data = '0; s_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dut0", {out_data, busy, frame_done, underrun, s_ready}, 32'b00001);
    chk("rst_dut1", {out1, busy1, fd1, ur1, rdy1}, 32'b00001);
    rst = 1'b0;
    @(negedge clk);

    // Single-word frames, including the parity corner words.
    for (int i = 0; i < 6; i++) begin
      fd0 = fd_cnt; ur0 = ur_cnt;
      send(tbl[i].m, tbl[i].d, 1'b1, tbl[i].pe, tbl[i].po, st);
      chk("lat_idle_t1", 32'(busy), 0);
      @(negedge clk);
      chk("lat_first_half_t2", {busy, out_data}, {31'd1, ~tbl[i].m});
      wait_cnt(1'b0, fd0 + 1, "single_frame_done");
      chk("single_no_underrun", ur_cnt - ur0, 0);
      chk("single_ready", 32'(s_ready), 1);
    end

    // Back-to-back words with the third one stalled behind a full register.
    fd0 = fd_cnt; ur0 = ur_cnt; a0 = acc_cnt;
    send(1'b1, 30'h15555555, 1'b0, par(1'b1, 30'h15555555), ~par(1'b1, 30'h15555555), st);
    send(1'b0, 30'h0F0F0F0F, 1'b0, par(1'b0, 30'h0F0F0F0F), ~par(1'b0, 30'h0F0F0F0F), st);
    send(1'b1, 30'h00C0FFEE, 1'b1, par(1'b1, 30'h00C0FFEE), ~par(1'b1, 30'h00C0FFEE), st);
    chk("bp_stalled", 32'(st > 50), 1);
    wait_cnt(1'b0, fd0 + 1, "b2b_frame_done");
    repeat (20) @(negedge clk);
    chk("b2b_one_frame_done", fd_cnt - fd0, 1);
    chk("b2b_no_underrun", ur_cnt - ur0, 0);
    chk("b2b_captured_once", acc_cnt - a0, 3);

    // Underrun: second word arrives 10 cycles after the first ends.
    fd0 = fd_cnt; ur0 = ur_cnt;
    send(1'b1, 30'h0000ABCD, 1'b0, par(1'b1, 30'h0000ABCD), ~par(1'b1, 30'h0000ABCD), st);
    wait_cnt(1'b1, ur0 + 1, "underrun_seen");
    repeat (9) @(negedge clk);
    send(1'b0, 30'h2000_0001, 1'b1, par(1'b0, 30'h20000001), ~par(1'b0, 30'h20000001), st);
    wait_cnt(1'b0, fd0 + 2, "underrun_two_frames");
    chk("underrun_count", ur_cnt - ur0, 1);

    // Reset mid-word with a second word waiting in the holding register.
    fd0 = fd_cnt;
    send(1'b1, 30'h3F00FF00, 1'b1, par(1'b1, 30'h3F00FF00), ~par(1'b1, 30'h3F00FF00), st);
    send(1'b0, 30'h00000055, 1'b1, par(1'b0, 30'h00000055), ~par(1'b0, 30'h00000055), st);
    repeat (46) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_word", {out_data, busy, s_ready}, 32'b001);
    rst = 1'b0;
    seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (busy || out_data) seen++;
    end
    chk("rst_hold_cleared", seen, 0);
    chk("rst_no_frame_done", fd_cnt - fd0, 0);
    send(1'b1, 30'h1234ABCD, 1'b1, par(1'b1, 30'h1234ABCD), ~par(1'b1, 30'h1234ABCD), st);
    wait_cnt(1'b0, fd0 + 1, "post_rst_frame_done");

    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
